// File: rtl/stream_queue_bank_pkg.sv
// rtl/stream_queue_bank_pkg.sv - width helpers shared by the stream queue bank and its channels
package stream_queue_bank_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Pointer width for a DEPTH-entry ring; a 1-entry ring would otherwise get 0 bits.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_queue_chan.sv
// rtl/stream_queue_chan.sv - one show-ahead stream queue channel (data + eos), optional STREAM_QUEUE_HWM_EN high-water mark
module stream_queue_chan
  import stream_queue_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SLACK = 0,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_eos_i,
  input  logic             in_valid_i,
  output logic             in_busy_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_eos_o,
  output logic             out_valid_o,
  input  logic             out_busy_i,
  output logic [CW-1:0]    occ_o,
  output logic             ovf_o
`ifdef STREAM_QUEUE_HWM_EN
  ,
  output logic [CW-1:0]    hwm_o
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - SLACK);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            rd, wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A full queue still accepts when the head leaves in the same cycle.
  always_comb begin
    rd       = (count_q != '0) && !out_busy_i;
    wr       = in_valid_i && ((count_q < FULL) || rd);
    count_d  = count_q;
    if (wr && !rd) count_d = count_q + CW'(1);
    else if (rd && !wr) count_d = count_q - CW'(1);
    wr_ptr_d = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ovf_d    = ovf_q | (in_valid_i & ~wr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[wr_ptr_q] <= {in_eos_i, in_data_i};
  end

`ifdef STREAM_QUEUE_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm_o = hwm_q;
`endif

  assign out_valid_o             = (count_q != '0);
  assign {out_eos_o, out_data_o} = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign in_busy_o               = (count_q >= THRESH);
  assign occ_o                   = count_q;
  assign ovf_o                   = ovf_q;

endmodule

// File: rtl/stream_queue_bank.sv
// rtl/stream_queue_bank.sv - NCH independent stream queues; hwm port present with STREAM_QUEUE_HWM_EN
module stream_queue_bank
  import stream_queue_bank_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int SLACK = 0,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] qin_d,
  input  logic [NCH-1:0]       qin_e,
  input  logic [NCH-1:0]       qin_v,
  output logic [NCH-1:0]       qin_b,
  output logic [NCH*WIDTH-1:0] qout_d,
  output logic [NCH-1:0]       qout_e,
  output logic [NCH-1:0]       qout_v,
  input  logic [NCH-1:0]       qout_b,
  output logic [NCH*CW-1:0]    occ,
  output logic [NCH-1:0]       ovf
`ifdef STREAM_QUEUE_HWM_EN
  ,
  output logic [NCH*CW-1:0]    hwm
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    stream_queue_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SLACK (SLACK),
      .CW    (CW)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .in_data_i   (qin_d[i*WIDTH +: WIDTH]),
      .in_eos_i    (qin_e[i]),
      .in_valid_i  (qin_v[i]),
      .in_busy_o   (qin_b[i]),
      .out_data_o  (qout_d[i*WIDTH +: WIDTH]),
      .out_eos_o   (qout_e[i]),
      .out_valid_o (qout_v[i]),
      .out_busy_i  (qout_b[i]),
      .occ_o       (occ[i*CW +: CW]),
      .ovf_o       (ovf[i])
`ifdef STREAM_QUEUE_HWM_EN
      ,
      .hwm_o       (hwm[i*CW +: CW])
`endif
    );
  end

endmodule
